turbo_encoder_par: RTL and testbench

TURBO_ENCODER_PAR -- requirements
Module: turbo_encoder_par

---
 rtl/turbo_encoder_par.sv | 208 ++++++++++++++++++++
 tb/tb_turbo_encoder_par.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_encoder_par.sv
// Parallel-concatenated turbo encoder: one block of BLOCK_LEN bits is buffered,
// then streamed as (x, z1, z2) beats through two 8-state RSC encoders, the
// second fed via an additive-step interleaver, followed by 3 trellis
// termination beats. Optional rate-1/2 puncturing of the parity pair.
module turbo_encoder_par #(
  parameter int BLOCK_LEN = 40,
  parameter int IDX_W     = 6,
  parameter int INTLV_A   = 13
) (
  input  logic clk,
  input  logic rst_N,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  input  logic rate_half,
  output logic out_sys,
  output logic out_p1,
  output logic out_p2,
  output logic out_valid,
  input  logic out_ready,
  output logic out_tail,
  output logic out_last
);

  typedef enum logic [1:0] {LOAD, ENCODE, TERM} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);
  localparam logic [IDX_W:0]   K_EXT    = (IDX_W+1)'(BLOCK_LEN);
  localparam logic [IDX_W:0]   A_EXT    = (IDX_W+1)'(INTLV_A);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] step_q, step_d;   // index of the beat currently on the output
  logic [IDX_W-1:0] pi_q, pi_d;       // pi(step_q)
  logic [2:0]       s1_q, s1_d, s2_q, s2_d;
  logic             punct_q, punct_d;
  logic [1:0]       term_q, term_d;   // tail beat index currently on the output
  logic             ov_q, ov_d, sys_q, sys_d, p1_q, p1_d, p2_q, p2_d;
  logic             tail_q, tail_d, last_q, last_d;

  logic             blk_q [BLOCK_LEN];

  // Interleaver and encoder datapath for the next beat to be produced
  logic [IDX_W:0]   pi_sum;
  logic [IDX_W-1:0] pi_nxt, rd_i, rd_p;
  logic             u1, u2, f1, f2, z1, z2;
  logic             tu1, tu2, tz1, tz2;

  assign pi_sum = {1'b0, pi_q} + A_EXT;
  assign pi_nxt = (pi_sum >= K_EXT) ? IDX_W'(pi_sum - K_EXT) : pi_sum[IDX_W-1:0];

  // From LOAD the next beat is step 0 (pi(0) = 0); otherwise step_q + 1
  assign rd_i = (state_q == LOAD) ? '0 : step_q + IDX_W'(1);
  assign rd_p = (state_q == LOAD) ? '0 : pi_nxt;

  assign u1 = blk_q[rd_i];
  assign u2 = blk_q[rd_p];
  assign f1 = u1 ^ s1_q[1] ^ s1_q[2];
  assign f2 = u2 ^ s2_q[1] ^ s2_q[2];
  assign z1 = f1 ^ s1_q[0] ^ s1_q[2];
  assign z2 = f2 ^ s2_q[0] ^ s2_q[2];

  // Termination input cancels the feedback, so f = 0 and the state drains
  assign tu1 = s1_q[1] ^ s1_q[2];
  assign tu2 = s2_q[1] ^ s2_q[2];
  assign tz1 = s1_q[0] ^ s1_q[2];
  assign tz2 = s2_q[0] ^ s2_q[2];

  assign in_ready  = (state_q == LOAD);
  assign out_valid = ov_q;
  assign out_sys   = sys_q;
  assign out_p1    = p1_q;
  assign out_p2    = p2_q;
  assign out_tail  = tail_q;
  assign out_last  = last_q;

  // Block buffer: written only while loading, no reset needed
  always_ff @(posedge clk) begin
    if (state_q == LOAD && in_valid) blk_q[wr_idx_q] <= in_bit;
  end

  // Next-state and output-beat generation; everything holds unless a
  // transfer (or the final load) lets the next beat be produced
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    step_d   = step_q;
    pi_d     = pi_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    punct_d  = punct_q;
    term_d   = term_q;
    ov_d     = ov_q;
    sys_d    = sys_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    tail_d   = tail_q;
    last_d   = last_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == '0) punct_d = rate_half;
          if (wr_idx_q == LAST_IDX) begin
            // Step 0 only reads buf[0], already written, so beat 0 is
            // produced in the same cycle the last bit lands
            wr_idx_d = '0;
            state_d  = ENCODE;
            step_d   = '0;
            pi_d     = '0;
            ov_d     = 1'b1;
            sys_d    = u1;
            p1_d     = z1;
            p2_d     = punct_q ? 1'b0 : z2;
            tail_d   = 1'b0;
            last_d   = 1'b0;
            s1_d     = {s1_q[1:0], f1};
            s2_d     = {s2_q[1:0], f2};
          end
        end
      end
      ENCODE: begin
        if (ov_q && out_ready) begin
          if (step_q == LAST_IDX) begin
            state_d = TERM;
            term_d  = '0;
            sys_d   = tu1;
            p1_d    = tz1;
            p2_d    = tz2;
            tail_d  = 1'b1;
            last_d  = 1'b0;
            s1_d    = {s1_q[1:0], 1'b0};
            s2_d    = {s2_q[1:0], 1'b0};
          end else begin
            step_d = rd_i;
            pi_d   = rd_p;
            sys_d  = u1;
            p1_d   = (punct_q && rd_i[0]) ? z2 : z1;
            p2_d   = punct_q ? 1'b0 : z2;
            s1_d   = {s1_q[1:0], f1};
            s2_d   = {s2_q[1:0], f2};
          end
        end
      end
      TERM: begin
        if (ov_q && out_ready) begin
          if (term_q == 2'd2) begin
            state_d = LOAD;
            step_d  = '0;
            pi_d    = '0;
            term_d  = '0;
            ov_d    = 1'b0;
            sys_d   = 1'b0;
            p1_d    = 1'b0;
            p2_d    = 1'b0;
            tail_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            term_d = term_q + 2'd1;
            sys_d  = tu1;
            p1_d   = tz1;
            p2_d   = tz2;
            last_d = (term_q == 2'd1);
            s1_d   = {s1_q[1:0], 1'b0};
            s2_d   = {s2_q[1:0], 1'b0};
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State register with asynchronous reset to an idle, empty LOAD
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      step_q   <= '0;
      pi_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      punct_q  <= 1'b0;
      term_q   <= '0;
      ov_q     <= 1'b0;
      sys_q    <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      tail_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      step_q   <= step_d;
      pi_q     <= pi_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      punct_q  <= punct_d;
      term_q   <= term_d;
      ov_q     <= ov_d;
      sys_q    <= sys_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      tail_q   <= tail_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_turbo_encoder_par.sv
// Directed bench for turbo_encoder_par (K=40, A=13). A behavioural model
// pushes expected beats {x,p1,p2,tail,last} into a scoreboard when a block is
// loaded; a monitor pops and compares each transferred beat.
module tb_turbo_encoder_par;
  localparam int K = 40;
  localparam int A = 13;

  logic clk = 1'b0;
  logic rst_N, in_bit, in_valid, rate_half, out_ready;
  logic in_ready, out_sys, out_p1, out_p2, out_valid, out_tail, out_last;

  int checks = 0;
  int fails = 0;
  int beats_seen = 0;
  logic [4:0] sb_q[$];
  logic [4:0] log_q[$];
  logic [4:0] mon_obs, mon_exp, snap;
  logic [63:0] rnd;

  turbo_encoder_par #(.BLOCK_LEN(K), .IDX_W(6), .INTLV_A(A)) dut (
    .clk(clk), .rst_N(rst_N), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .rate_half(rate_half), .out_sys(out_sys),
    .out_p1(out_p1), .out_p2(out_p2), .out_valid(out_valid),
    .out_ready(out_ready), .out_tail(out_tail), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // returns {z, next_state}
  function automatic logic [3:0] enc_step(input logic u, input logic [2:0] s);
    logic f;
    f = u ^ s[1] ^ s[2];
    return {f ^ s[0] ^ s[2], s[1], s[0], f};
  endfunction

  task automatic push_model(input logic [K-1:0] bits, input logic rh);
    logic [2:0] s1 = '0;
    logic [2:0] s2 = '0;
    logic [3:0] r1, r2;
    logic u1, u2, p1, p2;
    for (int i = 0; i < K; i++) begin
      u1 = bits[i];
      u2 = bits[(i * A) % K];
      r1 = enc_step(u1, s1);
      r2 = enc_step(u2, s2);
      p1 = (rh && (i % 2 == 1)) ? r2[3] : r1[3];
      p2 = rh ? 1'b0 : r2[3];
      sb_q.push_back({u1, p1, p2, 2'b00});
      s1 = r1[2:0];
      s2 = r2[2:0];
    end
    for (int t = 0; t < 3; t++) begin
      u1 = s1[1] ^ s1[2];
      u2 = s2[1] ^ s2[2];
      r1 = enc_step(u1, s1);
      r2 = enc_step(u2, s2);
      sb_q.push_back({u1, r1[3], r2[3], 1'b1, (t == 2)});
      s1 = r1[2:0];
      s2 = r2[2:0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads one block; rate_half is only correct on bit 0 so that late
  // sampling shows up. Junk in_valid cycles follow while in_ready is low.
  task automatic load_block(input logic [K-1:0] bits, input logic rh, input int junk);
    log_q.delete();
    beats_seen = 0;
    push_model(bits, rh);
    chk("in_ready_load", 32'(in_ready), 32'(1));
    for (int i = 0; i < K; i++) begin
      in_valid = 1'b1;
      in_bit = bits[i];
      rate_half = (i == 0) ? rh : ~rh;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("first_beat_valid", 32'(out_valid), 32'(1));
    chk("in_ready_busy", 32'(in_ready), 32'(0));
    for (int j = 0; j < junk; j++) begin
      in_valid = 1'b1;
      in_bit = ~bits[j];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_block(input int n);
    int cyc = 0;
    while (beats_seen < n && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("beat_count", 32'(beats_seen), 32'(n));
    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    chk("in_ready_after", 32'(in_ready), 32'(1));
    chk("out_valid_after", 32'(out_valid), 32'(0));
    for (int k = 0; k < log_q.size(); k++)
      chk($sformatf("tail_last_b%0d", k), 32'(log_q[k][1:0]), 32'({k >= K, k == K + 2}));
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (beats_seen < n && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("reach_beat", 32'(beats_seen >= n), 32'(1));
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_N && out_valid && out_ready) begin
          mon_obs = {out_sys, out_p1, out_p2, out_tail, out_last};
          log_q.push_back(mon_obs);
          checks++;
          assert (sb_q.size() != 0) else begin
            fails++;
            $error("FAIL sb_underflow observed beat=%b expected=none", mon_obs);
          end
          if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            checks++;
            assert (mon_obs === mon_exp) else begin
              fails++;
              $error("FAIL beat%0d observed=%b expected=%b", beats_seen, mon_obs, mon_exp);
            end
          end
          beats_seen++;
        end
      end
    join_none

    rst_N = 1'b0; in_bit = 1'b0; in_valid = 1'b0; rate_half = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_outs", 32'({out_sys, out_p1, out_p2, out_tail, out_last}), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_N = 1'b1;

    // all-zero block
    load_block('0, 1'b0, 0);
    finish_block(K + 3);
    for (int k = 0; k < K + 3; k++)
      chk($sformatf("zero_data_b%0d", k), 32'(log_q[k][4:2]), 32'(0));

    // impulse at bit 0: recurrence gives parity 1,1,1,1 on beats 0..3
    load_block(40'h1, 1'b0, 6);
    finish_block(K + 3);
    chk("imp_b0", 32'(log_q[0]), 32'(5'b11100));
    chk("imp_b1", 32'(log_q[1]), 32'(5'b01100));
    chk("imp_b2", 32'(log_q[2]), 32'(5'b01100));
    chk("imp_b3", 32'(log_q[3]), 32'(5'b01100));
    chk("enc1_zero", 32'(dut.s1_q), 32'(0));
    chk("enc2_zero", 32'(dut.s2_q), 32'(0));

    // interleaver: pi(1)=13, pi(3)=39, pi(4)=12
    load_block(40'h1 << 13, 1'b0, 0);
    finish_block(K + 3);
    chk("pi1_pre", 32'(log_q[0][2]), 32'(0));
    chk("pi1_hit", 32'(log_q[1][2]), 32'(1));
    load_block(40'h1 << 39, 1'b0, 0);
    finish_block(K + 3);
    chk("pi3_pre", 32'({log_q[0][2], log_q[1][2], log_q[2][2]}), 32'(0));
    chk("pi3_hit", 32'(log_q[3][2]), 32'(1));
    load_block(40'h1 << 12, 1'b0, 0);
    finish_block(K + 3);
    chk("pi4_pre", 32'({log_q[0][2], log_q[1][2], log_q[2][2], log_q[3][2]}), 32'(0));
    chk("pi4_hit", 32'(log_q[4][2]), 32'(1));

    // random block with a backpressure stall at beat 20
    rnd = {$urandom, $urandom};
    load_block(rnd[K-1:0], 1'b0, 6);
    wait_beats(20);
    out_ready = 1'b0;
    snap = {out_sys, out_p1, out_p2, out_tail, out_last};
    chk("stall_beat20", 32'(snap), 32'(sb_q[0]));
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", 32'({out_valid, out_sys, out_p1, out_p2, out_tail, out_last}), 32'({1'b1, snap}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    finish_block(K + 3);

    // punctured random block
    rnd = {$urandom, $urandom};
    load_block(rnd[K-1:0], 1'b1, 0);
    finish_block(K + 3);
    for (int k = 0; k < K; k++)
      chk($sformatf("punct_p2_b%0d", k), 32'(log_q[k][2]), 32'(0));

    // reset mid-block, then a fresh block
    rnd = {$urandom, $urandom};
    load_block(rnd[K-1:0], 1'b0, 0);
    wait_beats(10);
    rst_N = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_outs", 32'({out_sys, out_p1, out_p2, out_tail, out_last}), 32'(0));
    @(posedge clk); #1;
    chk("midrst_hold_valid", 32'(out_valid), 32'(0));
    rst_N = 1'b1;
    sb_q.delete();
    chk("postrst_in_ready", 32'(in_ready), 32'(1));
    rnd = {$urandom, $urandom};
    load_block(rnd[K-1:0], 1'b0, 0);
    finish_block(K + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
